// File: rtl/volatility_rd_ctrl.sv
// volatility_rd_ctrl: mirrors per-stock write pointers and streams one stock's window oldest->newest.
// Define VOL_RD_ACCUM_EN to build the o_sum window accumulator; otherwise o_sum is tied to 0.
module volatility_rd_ctrl #(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  parameter int DATA_WIDTH  = 32,
  localparam int SW   = $clog2(NUM_STOCKS),
  localparam int AW   = $clog2(NUM_STOCKS * BUFFER_SIZE),
  localparam int LW   = $clog2(BUFFER_SIZE),
  localparam int CW   = $clog2(BUFFER_SIZE + 1),
  localparam int SUMW = DATA_WIDTH + CW
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_valid,
  input  logic [SW-1:0]         i_wr_stock_id,
  input  logic                  i_rd_req,
  input  logic [SW-1:0]         i_rd_stock_id,
  output logic                  o_req_ready,
  output logic                  o_mem_rd_en,
  output logic [AW-1:0]         o_mem_rd_address,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_valid,
  output logic                  o_sample_last,
  input  logic                  i_sample_ready,
  output logic                  o_done,
  output logic [CW-1:0]         o_count,
  output logic [SUMW-1:0]       o_sum
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LW-1:0] ptr [NUM_STOCKS];
  logic [CW-1:0] cnt [NUM_STOCKS];
  logic [SW-1:0] sid;
  logic [LW-1:0] loc;
  logic [CW-1:0] iss;
  logic infl, infl_last;
  logic [DATA_WIDTH-1:0] f_d [2];
  logic f_l [2];
  logic [1:0] fcnt;
  logic acc, pop, push, fifo_pop, wr_idx;
  assign acc = i_rd_req && o_req_ready;
  always_ff @(posedge i_clk)
    if (i_reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = cnt[i_rd_stock_id] == '0 ? DONE : READ;
      READ:    if (o_mem_rd_en && iss == o_count - CW'(1)) state_nx = DRAIN;
      DRAIN:   if (pop && o_sample_last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Credit: FIFO entries plus the read in flight never exceed the two FIFO slots.
  always_comb begin
    o_req_ready = state == IDLE;
    o_done      = state == DONE;
    o_mem_rd_en = state == READ && (fcnt == 2'd0 || (fcnt == 2'd1 && !infl));
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr[s] <= '0;
        cnt[s] <= '0;
      end
    end else if (i_wr_valid) begin
      ptr[i_wr_stock_id] <= ptr[i_wr_stock_id] == LW'(BUFFER_SIZE - 1) ? '0 : ptr[i_wr_stock_id] + LW'(1);
      cnt[i_wr_stock_id] <= cnt[i_wr_stock_id] == CW'(BUFFER_SIZE) ? cnt[i_wr_stock_id] : cnt[i_wr_stock_id] + CW'(1);
    end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      sid     <= '0;
      loc     <= '0;
      iss     <= '0;
      o_count <= '0;
    end else if (acc) begin
      sid     <= i_rd_stock_id;
      loc     <= cnt[i_rd_stock_id] < CW'(BUFFER_SIZE) ? '0 : ptr[i_rd_stock_id];
      iss     <= '0;
      o_count <= cnt[i_rd_stock_id];
    end else if (o_mem_rd_en) begin
      loc <= loc == LW'(BUFFER_SIZE - 1) ? '0 : loc + LW'(1);
      iss <= iss + CW'(1);
    end
  assign o_mem_rd_address = AW'(sid) * AW'(BUFFER_SIZE) + AW'(loc);
  // Returning data bypasses an empty FIFO so the first sample appears the cycle after its read.
  assign o_sample_valid = fcnt != 2'd0 || infl;
  assign o_sample       = fcnt != 2'd0 ? f_d[0] : infl ? i_mem_rd_data : '0;
  assign o_sample_last  = fcnt != 2'd0 ? f_l[0] : infl && infl_last;
  assign pop      = o_sample_valid && i_sample_ready;
  assign fifo_pop = pop && fcnt != 2'd0;
  assign push     = infl && !(pop && fcnt == 2'd0);
  assign wr_idx   = fcnt[0] && !fifo_pop;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      infl      <= 1'b0;
      infl_last <= 1'b0;
      fcnt      <= '0;
    end else begin
      infl      <= o_mem_rd_en;
      infl_last <= iss == o_count - CW'(1);
      if (fifo_pop) begin
        f_d[0] <= f_d[1];
        f_l[0] <= f_l[1];
      end
      if (push) begin
        f_d[wr_idx] <= i_mem_rd_data;
        f_l[wr_idx] <= infl_last;
      end
      fcnt <= fcnt - {1'b0, fifo_pop} + {1'b0, push};
    end
`ifdef VOL_RD_ACCUM_EN
  always_ff @(posedge i_clk)
    if (i_reset || acc) o_sum <= '0;
    else if (pop) o_sum <= o_sum + SUMW'(o_sample);
`else
  assign o_sum = '0;
`endif
endmodule

// File: tb/tb_volatility_rd_ctrl.sv
// tb_volatility_rd_ctrl: table-driven window reads against a behavioural buffer memory.
module tb_volatility_rd_ctrl;
  localparam int NS = 4, BS = 20, DW = 32;
`ifdef VOL_RD_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic i_clk = 0, i_reset = 1, i_wr_valid = 0, i_rd_req = 0, i_sample_ready = 0;
  logic [1:0] i_wr_stock_id = 0, i_rd_stock_id = 0;
  logic o_req_ready, o_mem_rd_en, o_sample_valid, o_sample_last, o_done;
  logic [6:0] o_mem_rd_address;
  logic [DW-1:0] i_mem_rd_data = 0, o_sample, wr_val = 0;
  logic [4:0] o_count;
  logic [36:0] o_sum;
  logic [DW-1:0] mem [NS*BS];
  int wp [NS];
  int n_chk = 0, n_fail = 0;
  typedef struct {
    int wr_stock; int wr_n; int wr_base; int mid_n; int rd_stock; int rdy_pat;
    int exp_count; int exp_sum; int exp_addr0; int exp_first; int exp_done;
  } vec_t;
  vec_t vecs [6];
  vec_t vpost;

  always #5 i_clk = ~i_clk;

  volatility_rd_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr_valid(i_wr_valid), .i_wr_stock_id(i_wr_stock_id),
    .i_rd_req(i_rd_req), .i_rd_stock_id(i_rd_stock_id), .o_req_ready(o_req_ready),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_address(o_mem_rd_address), .i_mem_rd_data(i_mem_rd_data),
    .o_sample(o_sample), .o_sample_valid(o_sample_valid), .o_sample_last(o_sample_last),
    .i_sample_ready(i_sample_ready), .o_done(o_done), .o_count(o_count), .o_sum(o_sum)
  );

  always @(posedge i_clk) begin
    if (i_reset) for (int s = 0; s < NS; s++) wp[s] <= 0;
    else if (i_wr_valid) begin
      mem[int'(i_wr_stock_id) * BS + wp[i_wr_stock_id]] <= wr_val;
      wp[i_wr_stock_id] <= (wp[i_wr_stock_id] + 1) % BS;
    end
    if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_rd_address];
  end

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic write_n(input int s, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_wr_valid = 1; i_wr_stock_id = 2'(s); wr_val = DW'(base + i);
      @(posedge i_clk); #1;
    end
    i_wr_valid = 0;
  endtask

  task automatic run_read(input vec_t v);
    int cyc = 0, na = 0, ns = 0, mid = 0, dcyc = -1, mx = 0;
    logic [DW-1:0] ps = 0;
    logic pl = 0, pst = 0;
    chk("req_ready_idle", o_req_ready, 1);
    i_rd_req = 1; i_rd_stock_id = 2'(v.rd_stock);
    if (mid < v.mid_n) begin
      i_wr_valid = 1; i_wr_stock_id = 2'(v.rd_stock); wr_val = DW'(v.wr_base + v.wr_n + mid); mid++;
    end
    @(posedge i_clk); #1;
    i_rd_req = 0;
    while (dcyc < 0 && cyc < 300) begin
      cyc++;
      if (mid < v.mid_n) begin
        i_wr_valid = 1; wr_val = DW'(v.wr_base + v.wr_n + mid); mid++;
      end else i_wr_valid = 0;
      i_sample_ready = ((v.rdy_pat >> (3 - (cyc - 1) % 4)) & 1) != 0;
      @(negedge i_clk);
      if (cyc == 1) begin
        chk("count_after_accept", o_count, v.exp_count);
        chk("req_ready_busy", o_req_ready, 0);
      end
      if (pst) begin
        chk("stall_valid", o_sample_valid, 1);
        chk("stall_sample", o_sample, ps);
        chk("stall_last", o_sample_last, pl);
      end
      if (o_mem_rd_en) begin
        chk("rd_addr", o_mem_rd_address, v.rd_stock * BS + (v.exp_addr0 - v.rd_stock * BS + na) % BS);
        na++;
      end
      if (o_sample_valid && i_sample_ready) begin
        chk("sample", o_sample, v.exp_first + ns);
        chk("sample_last", o_sample_last, ns == v.exp_count - 1);
        ns++;
      end
      if (na - ns > mx) mx = na - ns;
      pst = o_sample_valid && !i_sample_ready; ps = o_sample; pl = o_sample_last;
      if (o_done) begin
        dcyc = cyc;
        chk("sum_at_done", o_sum, ACC ? v.exp_sum : 0);
      end
      @(posedge i_clk); #1;
    end
    i_wr_valid = 0;
    chk("done_seen", dcyc >= 0, 1);
    if (v.exp_done >= 0) chk("done_cycle", dcyc, v.exp_done);
    chk("reads_issued", na, v.exp_count);
    chk("samples_popped", ns, v.exp_count);
    chk("outstanding_le2", mx <= 2, 1);
    chk("done_one_cycle", o_done, 0);
    chk("req_ready_after", o_req_ready, 1);
    chk("sum_held", o_sum, ACC ? v.exp_sum : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, o_req_ready, 1);
    chk({tag, "_rd_en"}, o_mem_rd_en, 0);
    chk({tag, "_addr"}, o_mem_rd_address, 0);
    chk({tag, "_valid"}, o_sample_valid, 0);
    chk({tag, "_sample"}, o_sample, 0);
    chk({tag, "_last"}, o_sample_last, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_sum"}, o_sum, 0);
  endtask

  initial begin
    int ns, cyc, nd;
    //            wr_s wr_n base mid rd   rdy     cnt sum  a0  first done
    vecs[0] = '{0,  0,   0,   0,  2, 4'b1111, 0,  0,   40, 0,   1};
    vecs[1] = '{1,  5,   10,  0,  1, 4'b1111, 5,  60,  20, 10,  7};
    vecs[2] = '{0,  23,  1,   0,  0, 4'b1111, 20, 270, 3,  4,   22};
    vecs[3] = '{0,  0,   0,   0,  0, 4'b1001, 20, 270, 3,  4,   -1};
    vecs[4] = '{3,  3,   100, 2,  3, 4'b1111, 3,  303, 60, 100, 5};
    vecs[5] = '{3,  0,   100, 0,  3, 4'b1111, 5,  510, 60, 100, 7};
    vpost   = '{0,  0,   0,   0,  2, 4'b1111, 0,  0,   40, 0,   1};
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_reset = 0;
    for (int i = 0; i < 6; i++) begin
      write_n(vecs[i].wr_stock, vecs[i].wr_n, vecs[i].wr_base);
      run_read(vecs[i]);
    end
    i_sample_ready = 1; i_rd_req = 1; i_rd_stock_id = 0;
    @(posedge i_clk); #1;
    i_rd_req = 0;
    ns = 0; cyc = 0;
    while (ns < 7 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      if (o_sample_valid && i_sample_ready) ns++;
      if (ns < 7) begin
        @(posedge i_clk); #1;
      end
    end
    chk("reached_sample7", ns, 7);
    i_reset = 1;
    @(posedge i_clk); #1;
    check_reset_outputs("midreset");
    i_reset = 0;
    nd = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_done) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    @(posedge i_clk); #1;
    run_read(vpost);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
